// File: rtl/tick_generator_if.sv
// Configuration and readback port of the tick generator.
// The bus glue owns the master side; the generator owns the slave side.
interface tick_generator_if #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic             cfg_en;
    logic             cfg_mode;
    logic [CNT_W-1:0] cfg_val;
    logic [CH_W-1:0]  rd_ch;
    logic             rd_en;
    logic             rd_mode;
    logic [CNT_W-1:0] rd_val;

    modport master (
        output cfg_we, cfg_ch, cfg_en, cfg_mode, cfg_val, rd_ch,
        input  rd_en, rd_mode, rd_val
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_en, cfg_mode, cfg_val, rd_ch,
        output rd_en, rd_mode, rd_val
    );
endinterface

// File: rtl/tick_generator.sv
// Multi-channel tick / clock-enable generator. Each channel is either an
// integer reload divider or a fractional phase accumulator.
module tick_generator #(
    parameter int unsigned           NCH         = 3,
    parameter int unsigned           CNT_W       = 32,
    parameter logic [NCH*CNT_W-1:0]  RELOAD_INIT = {32'd867, 32'd9, 32'd99},
    parameter logic [NCH-1:0]        MODE_INIT   = {NCH{1'b0}},
    parameter logic [NCH-1:0]        EN_INIT     = {NCH{1'b1}}
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            sync,
    tick_generator_if.slave cfg,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  sq
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CNT_W-1:0] val_q [NCH];
    logic [CNT_W-1:0] val_d [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] acc_q [NCH];
    logic [CNT_W-1:0] acc_d [NCH];
    logic [CNT_W:0]   sum   [NCH];
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   en_q, en_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   sq_q, sq_d;
    logic [NCH-1:0]   wr_sel;

    // Out-of-range channel numbers match no channel, so such writes are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum[i] = {1'b0, acc_q[i]} + {1'b0, val_q[i]};
        end
    end

    always_comb begin
        val_d  = val_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        mode_d = mode_q;
        en_d   = en_q;
        sq_d   = sq_q;
        tick_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_sel[i]) begin
                // A write restarts the channel and wins over a coincident tick.
                val_d[i]  = cfg.cfg_val;
                mode_d[i] = cfg.cfg_mode;
                en_d[i]   = cfg.cfg_en;
                cnt_d[i]  = '0;
                acc_d[i]  = '0;
            end else if (sync) begin
                cnt_d[i] = '0;
                acc_d[i] = '0;
            end else if (en_q[i]) begin
                if (!mode_q[i]) begin
                    if (cnt_q[i] == val_q[i]) begin
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b1;
                        sq_d[i]   = ~sq_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    acc_d[i]  = sum[i][CNT_W-1:0];
                    tick_d[i] = sum[i][CNT_W];
                    sq_d[i]   = sq_q[i] ^ sum[i][CNT_W];
                end
            end
            if (sync) begin
                sq_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                val_q[i] <= RELOAD_INIT[i*CNT_W +: CNT_W];
                cnt_q[i] <= '0;
                acc_q[i] <= '0;
            end
            mode_q <= MODE_INIT;
            en_q   <= EN_INIT;
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                val_q[i] <= val_d[i];
                cnt_q[i] <= cnt_d[i];
                acc_q[i] <= acc_d[i];
            end
            mode_q <= mode_d;
            en_q   <= en_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    always_comb begin
        cfg.rd_en   = 1'b0;
        cfg.rd_mode = 1'b0;
        cfg.rd_val  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.rd_ch == CH_W'(i)) begin
                cfg.rd_en   = en_q[i];
                cfg.rd_mode = mode_q[i];
                cfg.rd_val  = val_q[i];
            end
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;
endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: defaults, writes, accumulator rates,
// enable, sync, out-of-range writes and asynchronous reset.
module tb_tick_generator;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sync  = 1'b0;
    logic [2:0] tick;
    logic [2:0] sq;

    int n_checks = 0;
    int n_fail   = 0;

    tick_generator_if #(.NCH(3), .CNT_W(32)) bus ();

    tick_generator dut (
        .clock (clock),
        .reset (reset),
        .sync  (sync),
        .cfg   (bus),
        .tick  (tick),
        .sq    (sq)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge after one rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cfg_write(input int ch, input logic en, input logic mode,
                             input logic [31:0] val);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'(ch);
        bus.cfg_en   = en;
        bus.cfg_mode = mode;
        bus.cfg_val  = val;
        step();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic check_rd(input string tag, input int ch, input logic en, input logic mode,
                            input logic [31:0] val);
        bus.rd_ch = 2'(ch);
        #1;
        check(tag, {bus.rd_en, bus.rd_mode, bus.rd_val}, {en, mode, val});
    endtask

    initial begin
        int err_tick;
        int err_sq;
        int cnt0;
        int cnt1;
        int cnt2;
        longint exp_acc;

        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_en   = 1'b0;
        bus.cfg_mode = 1'b0;
        bus.cfg_val  = '0;
        bus.rd_ch    = '0;

        // Reset defaults
        @(negedge clock);
        @(negedge clock);
        check("rst_tick", tick, 3'b000);
        check("rst_sq", sq, 3'b000);
        check_rd("rst_rd0", 0, 1'b1, 1'b0, 32'd99);
        check_rd("rst_rd1", 1, 1'b1, 1'b0, 32'd9);
        check_rd("rst_rd2", 2, 1'b1, 1'b0, 32'd867);
        check_rd("rst_rd3", 3, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        err_tick = 0;
        err_sq   = 0;
        cnt0     = 0;
        cnt1     = 0;
        cnt2     = 0;
        for (int e = 1; e <= 2000; e++) begin
            step();
            if (tick !== {(e % 868) == 0, (e % 10) == 0, (e % 100) == 0}) err_tick++;
            if (sq !== {((e / 868) % 2) == 1, ((e / 10) % 2) == 1, ((e / 100) % 2) == 1})
                err_sq++;
            cnt0 += int'(tick[0]);
            cnt1 += int'(tick[1]);
            cnt2 += int'(tick[2]);
        end
        check("def_tick_errs", err_tick, 0);
        check("def_sq_errs", err_sq, 0);
        check("def_cnt0", cnt0, 20);
        check("def_cnt1", cnt1, 200);
        check("def_cnt2", cnt2, 2);

        // ch1 write mid-period (cnt1 = 6)
        for (int k = 0; k < 6; k++) step();
        cfg_write(1, 1'b1, 1'b0, 32'd3);
        check("wr1_no_tick", tick[1], 1'b0);
        check_rd("wr1_rd", 1, 1'b1, 1'b0, 32'd3);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("wr1_k%0d", k), tick[1], (k % 4) == 0);
        end
        cfg_write(1, 1'b1, 1'b0, 32'd0);
        check("wr1v0_write_edge", tick[1], 1'b0);
        err_tick = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (tick[1] !== 1'b1) err_tick++;
        end
        check("wr1v0_high", err_tick, 0);

        // ch0 accumulator mode
        cfg_write(0, 1'b1, 1'b1, 32'h8000_0000);
        check("acc_half_wr", tick[0], 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("acc_half_k%0d", k), tick[0], (k % 2) == 0);
        end
        cfg_write(0, 1'b1, 1'b1, 32'h4000_0000);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("acc_quarter_k%0d", k), tick[0], (k % 4) == 0);
        end
        cfg_write(0, 1'b1, 1'b1, 32'd4947802);
        cnt0 = 0;
        for (int k = 1; k <= 40000; k++) begin
            step();
            cnt0 += int'(tick[0]);
        end
        exp_acc = (longint'(40000) * longint'(4947802)) >>> 32;
        check("acc_baud_cnt", cnt0, exp_acc);

        // ch2 enable / disable
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_tick", tick, 3'b000);
        check("sync_sq", sq, 3'b000);
        err_tick = 0;
        for (int k = 1; k <= 868; k++) begin
            step();
            if (k < 868 && tick[2] !== 1'b0) err_tick++;
        end
        check("ch2_tick868", tick[2], 1'b1);
        check("ch2_sq_after_tick", sq[2], 1'b1);
        for (int k = 1; k <= 500; k++) begin
            step();
            if (tick[2] !== 1'b0) err_tick++;
        end
        cfg_write(2, 1'b0, 1'b0, 32'd867);
        check("dis_sq", sq[2], 1'b1);
        check_rd("dis_rd", 2, 1'b0, 1'b0, 32'd867);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (tick[2] !== 1'b0) err_tick++;
        end
        check("dis_sq_hold", sq[2], 1'b1);
        cfg_write(2, 1'b1, 1'b0, 32'd867);
        check("reen_sq", sq[2], 1'b1);
        for (int k = 1; k <= 868; k++) begin
            step();
            if (k < 868 && tick[2] !== 1'b0) err_tick++;
        end
        check("ch2_quiet_errs", err_tick, 0);
        check("reen_tick868", tick[2], 1'b1);
        check("reen_sq_toggle", sq[2], 1'b0);

        // sync with a coincident ch1 tick and a ch0 write
        cfg_write(1, 1'b1, 1'b0, 32'd9);
        for (int k = 0; k < 9; k++) step();
        sync         = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'd0;
        bus.cfg_en   = 1'b1;
        bus.cfg_mode = 1'b0;
        bus.cfg_val  = 32'd4;
        step();
        sync       = 1'b0;
        bus.cfg_we = 1'b0;
        check("sync_wr_tick", tick, 3'b000);
        check("sync_wr_sq", sq, 3'b000);
        check_rd("sync_wr_rd0", 0, 1'b1, 1'b0, 32'd4);
        for (int k = 1; k <= 25; k++) begin
            if (k == 11) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_ch   = 2'd3;
                bus.cfg_en   = 1'b0;
                bus.cfg_mode = 1'b1;
                bus.cfg_val  = 32'd1;
            end
            step();
            bus.cfg_we = 1'b0;
            check($sformatf("realign_k%0d", k), tick, {1'b0, (k % 10) == 0, (k % 5) == 0});
        end
        check("realign_sq", sq, 3'b001);
        check_rd("oor_rd0", 0, 1'b1, 1'b0, 32'd4);
        check_rd("oor_rd1", 1, 1'b1, 1'b0, 32'd9);
        check_rd("oor_rd2", 2, 1'b1, 1'b0, 32'd867);
        check_rd("oor_rd3", 3, 1'b0, 1'b0, 32'd0);

        // Asynchronous reset between edges
        @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("arst_tick", tick, 3'b000);
        check("arst_sq", sq, 3'b000);
        check_rd("arst_rd0", 0, 1'b1, 1'b0, 32'd99);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("post_rst_k%0d", k), tick, {1'b0, k == 10, 1'b0});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Runtime-programmable, multi-channel tick and clock-enable generator. Replaces fixed compile-time dividers (RTC, slow clock, UART bit timing) with NCH independent channels.
- Each channel runs in one of two modes:
  - integer reload divider;
  - fractional phase accumulator, for exact baud rates.
- Each channel drives a single-cycle tick and a divided square-wave enable.
- Sits beside the CLINT and UART; the bus glue drives the config port.

Parameters:
- NCH, 3, number of channels.
- CNT_W, 32, width of the reload value, counter, increment and accumulator.
- RELOAD_INIT, {32'd867, 32'd9, 32'd99}, packed NCH*CNT_W reset reload values. Channel 0 is in the LSBs. Defaults are RTC 1MHz, slow 10MHz and UART 115200 at 100MHz.
- MODE_INIT, {NCH{1'b0}}, reset mode per channel (0 = integer, 1 = accumulator).
- EN_INIT, {NCH{1'b1}}, reset enable per channel.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- sync  in  1  realign all channels.
- cfg_we  in  1  single-cycle config write strobe.
- cfg_ch  in  $clog2(NCH)  target channel.
- cfg_en  in  1  channel enable.
- cfg_mode  in  1  0 = integer, 1 = accumulator.
- cfg_val  in  CNT_W  reload value (mode 0) or increment (mode 1).
- rd_ch  in  $clog2(NCH)  readback channel select.
- rd_en  out  1  enable of rd_ch (combinational).
- rd_mode  out  1  mode of rd_ch (combinational).
- rd_val  out  CNT_W  reload/increment of rd_ch (combinational).
- tick  out  NCH  one-cycle pulse per channel period (registered).
- sq  out  NCH  toggles on every tick of its channel (registered).

Behaviour:
- Reset (reset=0, asynchronous), per channel i:
  - val ← RELOAD_INIT[i], mode ← MODE_INIT[i], en ← EN_INIT[i];
  - cnt ← 0, acc ← 0, tick ← 0, sq ← 0.
- Mode 0 (integer), at each rising edge with en=1:
  - if cnt==val: cnt ← 0, tick ← 1, sq ← ~sq;
  - otherwise: cnt ← cnt+1, tick ← 0.
  - Period is val+1 cycles. The first tick is high after edge val+1 following reset release.
  - val=0 gives tick high every cycle.
- Mode 1 (accumulator), at each edge with en=1:
  - {carry, acc} ← acc + val (CNT_W+1-bit sum); tick ← carry; sq toggles on carry.
  - Average tick rate is f_clk*val/2^CNT_W.
  - val=0 produces no ticks.
- en=0: cnt, acc and sq hold; tick ← 0.
- Config write (cfg_we=1 at an edge, cfg_ch<NCH):
  - channel val/mode/en ← cfg fields;
  - cnt ← 0, acc ← 0, tick ← 0 on that edge; sq holds.
  - A tick that would have occurred on that edge is suppressed (the write wins).
  - Counting restarts on the next edge.
- cfg_ch≥NCH: the write is ignored and no state changes.
- sync=1 at an edge: every channel has cnt ← 0, acc ← 0, tick ← 0, sq ← 0; configuration is unchanged.
- sync and cfg_we on the same edge: both apply. The written channel takes the new config and is zeroed as by sync.
- Wrap-around:
  - cnt never exceeds val.
  - If a write lowers val below the current cnt, the write-reset clears cnt, so there is no overflow path.
  - acc wraps modulo 2^CNT_W by design.
- Readback is purely combinational from config registers. rd_ch≥NCH returns all zeros.
- Reset asserted mid-period clears everything immediately. There are no partial pulses after reset release.

Test Plan:
- Reset defaults, 2000 cycles:
  - ch1 tick at cycles 10, 20, 30…;
  - ch0 tick every 100 cycles;
  - ch2 tick every 868 cycles;
  - sq1 period 20 cycles;
  - readback ch2 = {en=1, mode=0, val=867}.
- Write ch1 mode=0 val=3 mid-period (cnt=6):
  - no tick on the write edge;
  - next ticks exactly 4, 8, 12 cycles after the write.
  - Write val=0: tick held high continuously.
- Write ch0 mode=1 val=32'h8000_0000: tick every 2nd cycle.
  - val=32'h4000_0000: tick every 4th cycle.
  - val=4947802: 10^8 cycles yield 115200±1 ticks (sample 10^6 cycles → 1152±1).
- Disable ch2 (en=0) at cnt=500, wait 300 cycles, then re-enable via a write with val=867:
  - no ticks while disabled;
  - first tick 868 cycles after the re-enable write;
  - sq unchanged across the write.
- Assert sync on the same edge as a ch1 tick, together with cfg_we to ch0:
  - that tick is suppressed and all sq are 0;
  - all channels realigned: ch1 next tick after 10 cycles, ch0 with its new config.
  - A write with cfg_ch=3 (out of range, NCH=3) changes nothing.
- Drop reset asynchronously between edges mid-count:
  - tick/sq go to 0 immediately;
  - after release, the first ch1 tick comes 10 edges later.
